// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the PLP writeback stage.
//   - WB_SRC_*  : result source select carried with each retiring instruction
//   - LD_SIZE_* : load access size
//   - wb_state_t: writeback control states
//   - ZERO_DATA : all-zero constant wide enough for any legal datapath
package wb_pkg;

  localparam logic [1:0] WB_SRC_ALU   = 2'd0;
  localparam logic [1:0] WB_SRC_JALRA = 2'd1;
  localparam logic [1:0] WB_SRC_LOAD  = 2'd2;
  localparam logic [1:0] WB_SRC_NONE  = 2'd3;

  localparam logic [1:0] LD_SIZE_B = 2'd0;
  localparam logic [1:0] LD_SIZE_H = 2'd1;
  localparam logic [1:0] LD_SIZE_W = 2'd2;
  localparam logic [1:0] LD_SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } wb_state_t;

  localparam logic [63:0] ZERO_DATA = 64'd0;

endpackage

// File: rtl/wb_stage_ext_ld_extract.sv
// ld_extract: combinational load lane select with sign/zero extension and
// alignment legality check.
// Ports:
//   rdata    in  W_DATA  raw memory word
//   addr_lo  in  W_LANE  byte offset of the access within the word
//   size     in  2       LD_SIZE_* encoding
//   sign_ext in  1       1 = replicate the lane's top bit, 0 = zero-fill
//   data     out W_DATA  extracted, extended value
//   illegal  out 1       misaligned offset or dword on a 32-bit datapath
module ld_extract
  import wb_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int W_LANE = $clog2(W_DATA / 8)
) (
  input  logic [W_DATA-1:0] rdata,
  input  logic [W_LANE-1:0] addr_lo,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [W_DATA-1:0] data,
  output logic              illegal
);

  localparam logic [W_DATA-1:0] ONES = '1;

  logic [W_DATA-1:0] shifted;
  logic [W_DATA-1:0] mask;
  logic              msb;

  // Move the addressed lane down to bit 0; masking then trims it to size.
  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    mask    = ONES;
    msb     = shifted[W_DATA-1];
    illegal = 1'b0;
    case (size)
      LD_SIZE_B: begin
        mask = ~(ONES << 8);
        msb  = shifted[7];
      end
      LD_SIZE_H: begin
        mask    = ~(ONES << 16);
        msb     = shifted[15];
        illegal = addr_lo[0];
      end
      LD_SIZE_W: begin
        // Shifting by the full width yields zero, so on a 32-bit datapath
        // the mask degenerates to all ones as intended.
        mask    = ~(ONES << 32);
        msb     = shifted[31];
        illegal = (addr_lo[1:0] != 2'd0);
      end
      default: begin
        mask    = ONES;
        msb     = shifted[W_DATA-1];
        illegal = (addr_lo != '0) || (W_DATA == 32);
      end
    endcase
    data = (shifted & mask) | ((sign_ext && msb) ? ~mask : '0);
  end

endmodule

// File: rtl/wb_stage_ext.sv
// wb_stage_ext: registered writeback stage. Retires ALU / link-address
// results with one cycle of latency and waits for late load responses,
// extracting and extending the addressed lane before the register write.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          MEM handshake; in_ready decoded from state only
//   in_rd/in_src/in_size/in_signed/in_addr_lo  instruction fields
//   in_alu_r/in_jalra          result candidates
//   flush                      cancel the outstanding load
//   mem_rvalid/mem_rdata       load response (single-cycle pulse)
//   rf_we/rf_waddr/rf_wdata    registered register-file write port
//   exc_misalign/exc_timeout   one-cycle exception pulses
//   err_spurious               sticky: response with no load outstanding
module wb_stage_ext
  import wb_pkg::*;
#(
  parameter int W_DATA      = 32,
  parameter int W_REG       = 5,
  parameter int TIMEOUT_CYC = 255,
  parameter int W_LANE      = $clog2(W_DATA / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_REG-1:0]  in_rd,
  input  logic [1:0]        in_src,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [W_LANE-1:0] in_addr_lo,
  input  logic [W_DATA-1:0] in_alu_r,
  input  logic [W_DATA-1:0] in_jalra,
  input  logic              flush,
  input  logic              mem_rvalid,
  input  logic [W_DATA-1:0] mem_rdata,
  output logic              rf_we,
  output logic [W_REG-1:0]  rf_waddr,
  output logic [W_DATA-1:0] rf_wdata,
  output logic              exc_misalign,
  output logic              exc_timeout,
  output logic              err_spurious
);

  localparam int              W_CNT   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
  // The counter holds the number of completed WAIT cycles, so the cycle in
  // which it equals TIMEOUT_CYC-1 is the last one allowed.
  localparam logic [W_CNT-1:0] TO_LAST = W_CNT'(TIMEOUT_CYC - 1);

  wb_state_t         state_q, state_d;
  logic [W_REG-1:0]  rd_q, rd_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [W_LANE-1:0] addr_q, addr_d;
  logic [W_CNT-1:0]  cnt_q, cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [W_REG-1:0]  rf_waddr_q, rf_waddr_d;
  logic [W_DATA-1:0] rf_wdata_q, rf_wdata_d;
  logic              mis_q, mis_d;
  logic              to_q, to_d;
  logic              spur_q, spur_d;

  // One extractor serves both jobs: in IDLE it checks the incoming load's
  // legality, otherwise it decodes the response using the captured fields.
  logic              sel_in;
  logic [W_LANE-1:0] ext_addr;
  logic [1:0]        ext_size;
  logic              ext_signed;
  logic [W_DATA-1:0] ext_data;
  logic              ext_illegal;

  assign sel_in     = (state_q == ST_IDLE);
  assign ext_addr   = sel_in ? in_addr_lo : addr_q;
  assign ext_size   = sel_in ? in_size    : size_q;
  assign ext_signed = sel_in ? in_signed  : signed_q;

  ld_extract #(.W_DATA(W_DATA), .W_LANE(W_LANE)) u_ld_extract (
    .rdata   (mem_rdata),
    .addr_lo (ext_addr),
    .size    (ext_size),
    .sign_ext(ext_signed),
    .data    (ext_data),
    .illegal (ext_illegal)
  );

  wire expire = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    size_d     = size_q;
    signed_d   = signed_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    mis_d      = 1'b0;
    to_d       = 1'b0;
    spur_d     = spur_q;
    case (state_q)
      ST_IDLE: begin
        // Includes a response arriving in the same cycle as a load accept.
        if (mem_rvalid) spur_d = 1'b1;
        if (in_valid) begin
          case (in_src)
            WB_SRC_ALU, WB_SRC_JALRA: begin
              rf_we_d    = (in_rd != '0);
              rf_waddr_d = in_rd;
              rf_wdata_d = (in_src == WB_SRC_ALU) ? in_alu_r : in_jalra;
            end
            WB_SRC_LOAD: begin
              if (ext_illegal) begin
                mis_d = 1'b1;
              end else begin
                rd_d     = in_rd;
                size_d   = in_size;
                signed_d = in_signed;
                addr_d   = in_addr_lo;
                cnt_d    = '0;
                state_d  = ST_WAIT;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = mem_rvalid ? ST_IDLE : ST_DRAIN;
        end else if (mem_rvalid) begin
          rf_we_d    = (rd_q != '0);
          rf_waddr_d = rd_q;
          rf_wdata_d = ext_data;
          state_d    = ST_IDLE;
        end else if (expire) begin
          to_d    = 1'b1;
          state_d = ST_DRAIN;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (mem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_q       <= '0;
      size_q     <= LD_SIZE_B;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= ZERO_DATA[W_DATA-1:0];
      mis_q      <= 1'b0;
      to_q       <= 1'b0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mis_q      <= mis_d;
      to_q       <= to_d;
      spur_q     <= spur_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign exc_misalign = mis_q;
  assign exc_timeout  = to_q;
  assign err_spurious = spur_q;

endmodule

// File: tb/tb_wb_stage_ext.sv
// Directed bench for wb_stage_ext (W_DATA=32, TIMEOUT_CYC=4). Inputs change
// 1 time unit after a rising edge; outputs are sampled there too, so each
// check observes the result of the previous edge.
module tb_wb_stage_ext;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_src;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_r;
  logic [31:0] in_jalra;
  logic        flush;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        exc_misalign;
  logic        exc_timeout;
  logic        err_spurious;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_stage_ext #(.W_DATA(32), .W_REG(5), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_src(in_src),
    .in_size(in_size), .in_signed(in_signed), .in_addr_lo(in_addr_lo),
    .in_alu_r(in_alu_r), .in_jalra(in_jalra), .flush(flush),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .exc_misalign(exc_misalign), .exc_timeout(exc_timeout),
    .err_spurious(err_spurious)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    in_src     = WB_SRC_NONE;
    flush      = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic drive(input logic [1:0] src, input logic [4:0] rd,
                       input logic [1:0] size, input logic sgn, input logic [1:0] lo);
    in_valid   = 1'b1;
    in_src     = src;
    in_rd      = rd;
    in_size    = size;
    in_signed  = sgn;
    in_addr_lo = lo;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_we"}, 64'(rf_we), 64'd1);
    chk({tag, "_waddr"}, 64'(rf_waddr), 64'(rd));
    chk({tag, "_wdata"}, 64'(rf_wdata), 64'(d));
    $display("txn %s: write rd=%0d data=%h", tag, rf_waddr, rf_wdata);
  endtask

  initial begin
    rst_n = 1'b0;
    in_rd = '0; in_size = '0; in_signed = 1'b0; in_addr_lo = '0;
    in_alu_r = '0; in_jalra = '0; mem_rdata = '0;
    idle_in();
    #1;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_spur", 64'(err_spurious), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // ALU then JALRA back to back
    drive(WB_SRC_ALU, 5'd3, 2'd0, 1'b0, 2'd0); in_alu_r = 32'h1234_5678;
    step();
    drive(WB_SRC_JALRA, 5'd31, 2'd0, 1'b0, 2'd0); in_jalra = 32'h0000_0400;
    chk_wr("alu", 5'd3, 32'h1234_5678);
    step();
    idle_in();
    chk_wr("jalra", 5'd31, 32'h0000_0400);
    step();
    chk("idle_we", 64'(rf_we), 64'd0);

    // rd 0 and src NONE never write
    drive(WB_SRC_ALU, 5'd0, 2'd0, 1'b0, 2'd0); in_alu_r = 32'h5;
    step();
    drive(WB_SRC_NONE, 5'd4, 2'd0, 1'b0, 2'd0);
    chk("rd0_we", 64'(rf_we), 64'd0);
    step();
    idle_in();
    chk("none_we", 64'(rf_we), 64'd0);

    // signed byte load, addr_lo=2, response in third WAIT cycle
    drive(WB_SRC_LOAD, 5'd7, LD_SIZE_B, 1'b1, 2'd2);
    step();
    idle_in();
    chk("ldsb_ready_wait", 64'(in_ready), 64'd0);
    step();
    chk("ldsb_we_wait", 64'(rf_we), 64'd0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h0080_0000;
    step();
    mem_rvalid = 1'b0;
    chk_wr("ldsb", 5'd7, 32'hFFFF_FF80);
    chk("ldsb_ready", 64'(in_ready), 64'd1);

    // unsigned repeat, response in first WAIT cycle
    drive(WB_SRC_LOAD, 5'd8, LD_SIZE_B, 1'b0, 2'd2);
    step();
    idle_in();
    mem_rvalid = 1'b1; mem_rdata = 32'h0080_0000;
    step();
    mem_rvalid = 1'b0;
    chk_wr("ldub", 5'd8, 32'h0000_0080);

    // signed half load at offset 2
    drive(WB_SRC_LOAD, 5'd6, LD_SIZE_H, 1'b1, 2'd2);
    step();
    idle_in();
    mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_1234;
    step();
    mem_rvalid = 1'b0;
    chk_wr("ldsh", 5'd6, 32'hFFFF_BEEF);

    // misaligned half, then dword on a 32-bit datapath
    drive(WB_SRC_LOAD, 5'd5, LD_SIZE_H, 1'b0, 2'd1);
    step();
    drive(WB_SRC_LOAD, 5'd5, LD_SIZE_D, 1'b0, 2'd0);
    chk("mis_h_exc", 64'(exc_misalign), 64'd1);
    chk("mis_h_we", 64'(rf_we), 64'd0);
    chk("mis_h_ready", 64'(in_ready), 64'd1);
    step();
    idle_in();
    chk("mis_d_exc", 64'(exc_misalign), 64'd1);
    chk("mis_d_ready", 64'(in_ready), 64'd1);
    step();
    chk("mis_pulse_end", 64'(exc_misalign), 64'd0);

    // flush two cycles after accept, response three cycles after flush
    drive(WB_SRC_LOAD, 5'd9, LD_SIZE_W, 1'b0, 2'd0);
    step();
    idle_in();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ready_drain", 64'(in_ready), 64'd0);
    step(); step();
    chk("flush_ready_drain2", 64'(in_ready), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    chk("flush_we", 64'(rf_we), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_spur", 64'(err_spurious), 64'd0);
    $display("txn flush: load dropped");

    // watchdog expiry, late response dropped
    drive(WB_SRC_LOAD, 5'd10, LD_SIZE_W, 1'b0, 2'd0);
    step();
    idle_in();
    step(); step(); step();
    chk("to_before", 64'(exc_timeout), 64'd0);
    chk("to_ready_wait", 64'(in_ready), 64'd0);
    step();
    chk("to_exc", 64'(exc_timeout), 64'd1);
    chk("to_we", 64'(rf_we), 64'd0);
    chk("to_ready_drain", 64'(in_ready), 64'd0);
    step();
    chk("to_pulse_end", 64'(exc_timeout), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00FF;
    step();
    mem_rvalid = 1'b0;
    chk("to_late_we", 64'(rf_we), 64'd0);
    chk("to_late_ready", 64'(in_ready), 64'd1);
    chk("to_late_spur", 64'(err_spurious), 64'd0);

    // response in the expiry cycle wins
    drive(WB_SRC_LOAD, 5'd11, LD_SIZE_B, 1'b0, 2'd0);
    step();
    idle_in();
    step(); step(); step();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_56AB;
    step();
    mem_rvalid = 1'b0;
    chk_wr("to_race", 5'd11, 32'h0000_00AB);
    chk("to_race_exc", 64'(exc_timeout), 64'd0);

    // flush together with the response
    drive(WB_SRC_LOAD, 5'd12, LD_SIZE_W, 1'b0, 2'd0);
    step();
    idle_in();
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    idle_in();
    chk("flushrv_we", 64'(rf_we), 64'd0);
    chk("flushrv_ready", 64'(in_ready), 64'd1);

    // spurious response in IDLE is sticky
    chk("spur_before", 64'(err_spurious), 64'd0);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk("spur_set", 64'(err_spurious), 64'd1);
    step(); step();
    chk("spur_sticky", 64'(err_spurious), 64'd1);

    // async reset while a load waits
    drive(WB_SRC_LOAD, 5'd13, LD_SIZE_W, 1'b0, 2'd0);
    step();
    idle_in();
    chk("prerst_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_waddr", 64'(rf_waddr), 64'd0);
    chk("arst_wdata", 64'(rf_wdata), 64'd0);
    chk("arst_spur", 64'(err_spurious), 64'd0);
    chk("arst_we", 64'(rf_we), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // recovery
    drive(WB_SRC_ALU, 5'd2, 2'd0, 1'b0, 2'd0); in_alu_r = 32'hCAFE_F00D;
    step();
    idle_in();
    chk_wr("recover", 5'd2, 32'hCAFE_F00D);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
